// File: rtl/sc_io_panel.sv
// I/O panel for sc_computer: double-dabble decimal display of out_port on six 7-segment digits,
// and debounced switches/keys into in_port. Define SC_IO_HEX_MODE_EN to add the hex_mode port.
module sc_io_panel #(
    parameter int unsigned WIDTH      = 20,
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic        clock,
    input  logic        reset,
`ifdef SC_IO_HEX_MODE_EN
    input  logic        hex_mode,
`endif
    input  logic [31:0] out_port,
    input  logic [9:0]  sw,
    input  logic [3:0]  key,
    output logic [31:0] in_port,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);
    localparam logic [6:0]  SegBlank = 7'b1111111;
    localparam logic [6:0]  SegDash  = 7'b0111111;
    localparam logic [6:0]  SegZero  = 7'b1000000;

    typedef enum logic [1:0] {StIdle, StConv, StLoad} state_e;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    logic             hex_mode_on;
    state_e           state_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shift_q;
    logic [27:0]      bcd_q;
    logic [27:0]      bcd_adj;
    logic [CntW-1:0]  bit_cnt_q;
    logic             mode_q;
    logic             busy_q;
    logic [6:0]       hex_q   [6];
    logic [6:0]       dec_seg [6];
    logic [6:0]       hx_seg  [6];
    logic             unused;

`ifdef SC_IO_HEX_MODE_EN
    assign hex_mode_on = hex_mode;
`else
    assign hex_mode_on = 1'b0;
`endif

    assign unused = ^{out_port, bcd_adj[27]};

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                          : bcd_q[i*4 +: 4];
        end
    end

    // Blank leading zeros from the top down; digit 0 is always shown.
    always_comb begin
        logic lead;
        lead = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            if (lead && bcd_q[i*4 +: 4] == 4'd0) begin
                dec_seg[i] = SegBlank;
            end else begin
                lead       = 1'b0;
                dec_seg[i] = seg7(bcd_q[i*4 +: 4]);
            end
        end
        dec_seg[0] = seg7(bcd_q[3:0]);
        if (bcd_q[27:24] != 4'd0) begin
            for (int i = 0; i < 6; i++) dec_seg[i] = SegDash;
        end
    end

    always_comb begin
        for (int i = 0; i < 6; i++) hx_seg[i] = seg7(out_port[i*4 +: 4]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            shadow_q  <= '0;
            shift_q   <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            hex_q[0]  <= SegZero;
            for (int i = 1; i < 6; i++) hex_q[i] <= SegBlank;
        end else begin
            mode_q <= hex_mode_on;
            if (hex_mode_on) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                hex_q   <= hx_seg;
            end else begin
                case (state_q)
                    StIdle: begin
                        // Leaving hex mode forces a reconversion of the current value.
                        if (out_port[WIDTH-1:0] != shadow_q || mode_q) begin
                            shadow_q  <= out_port[WIDTH-1:0];
                            shift_q   <= out_port[WIDTH-1:0];
                            bcd_q     <= '0;
                            bit_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= StConv;
                        end
                    end
                    StConv: begin
                        bcd_q     <= {bcd_adj[26:0], shift_q[WIDTH-1]};
                        shift_q   <= shift_q << 1;
                        bit_cnt_q <= bit_cnt_q + CntW'(1);
                        if (bit_cnt_q == CntW'(WIDTH - 1)) state_q <= StLoad;
                    end
                    StLoad: begin
                        hex_q   <= dec_seg;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
    assign busy = busy_q;

    logic [13:0]     sync1_q, sync2_q, prev_q, in_q;
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;

    always_comb begin
        if (sync2_q != prev_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DebW'(DEB_CYCLES - 1)) begin
            deb_cnt_d = deb_cnt_q;
        end else begin
            deb_cnt_d = deb_cnt_q + DebW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            deb_cnt_q <= '0;
            in_q      <= '0;
        end else begin
            sync1_q   <= {~key, sw};
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            deb_cnt_q <= deb_cnt_d;
            if (deb_cnt_d == DebW'(DEB_CYCLES - 1)) in_q <= sync2_q;
        end
    end

    assign in_port = {18'b0, in_q};

endmodule

// File: doc/sc_io_panel.md
Name: sc_io_panel

Overview:
Board-side endpoint of the sc_computer memory-mapped I/O ports. It consumes the CPU's `out_port` word and shows its low WIDTH bits as an unsigned decimal number on six 7-segment digits. The decimal conversion is a sequential double-dabble engine. It also produces the CPU's `in_port` word from debounced slide switches and push keys. It sits between the `sc_datamem` I/O ports and the board pins.

Parameters:
- WIDTH, 20: low bits of `out_port` that are displayed (1..20).
- DEB_CYCLES, 500000: number of stable cycles required before the input vector is accepted (10 ms at 50 MHz).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- out_port  in  32  word written by the CPU; only bits [WIDTH-1:0] are used
- sw  in  10  raw slide switches, asynchronous to clock
- key  in  4  raw push keys, active-low, asynchronous to clock
- in_port  out  32  debounced input word to the CPU
- hex0..hex5  out  7 each  segments, active-low, bit6=g .. bit0=a; hex0 is the least significant digit
- busy  out  1  high while a conversion is in progress

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Reset values:
  - hex0 = 7'b1000000 (shows "0"); hex1..hex5 = 7'b1111111 (blank).
  - in_port = 0, busy = 0.
  - Shadow register (last value converted) = 0; FSM in IDLE; debounce counter = 0; synchronizers = 0.
- FSM IDLE:
  - On an edge where out_port[WIDTH-1:0] differs from the shadow register: capture the value into both the shadow and shift registers, clear the BCD register (7 digits x 4 bits), set busy=1, go to CONV.
- FSM CONV:
  - Exactly WIDTH edges.
  - On each edge, every BCD digit that is >= 5 gets +3, then the {bcd, shift} pair shifts left by 1.
- FSM LOAD:
  - One edge: update the hex outputs, set busy=0, return to IDLE.
  - Latency: the hex outputs and busy=0 are visible WIDTH+1 edges after the capture edge. busy is high for WIDTH+1 cycles.
- out_port changes during CONV or LOAD are ignored. On return to IDLE the current out_port is compared against the shadow again, so the latest value is always displayed eventually. Intermediate values may be skipped.
- Display rules:
  - Leading-zero blanking: digits above the most significant nonzero digit are 7'b1111111. A value of 0 shows "0" on hex0 only.
  - Overflow: if the value exceeds 999999 (7th BCD digit nonzero), all six digits show "-" (7'b0111111).
  - Segment codes, 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Input path:
  - {key inverted, sw} (14 bits) passes through a 2-FF synchronizer.
  - A shared counter clears whenever the synchronized vector changes from its previous-cycle value, and otherwise increments.
  - When the counter reaches DEB_CYCLES-1, the vector is latched into in_port.
  - in_port mapping: [9:0] = sw, [13:10] = key pressed (active-high), [31:14] = 0.
  - Latency: 2 + DEB_CYCLES edges from a stable raw change. Any glitch shorter than DEB_CYCLES cycles is never reflected.
- Reset asserted mid-conversion: the FSM aborts to IDLE and all outputs take their reset values on that edge.

Optional Feature:
SC_IO_HEX_MODE_EN
- Defined:
  - Adds input port `hex_mode` (1 bit).
  - When hex_mode=1, hex5..hex0 show out_port[23:0] as six hexadecimal digits one edge after any change, with no blanking. WIDTH is ignored in this mode.
  - Codes for A..F: 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
  - The FSM stays in IDLE and busy=0.
  - A 0->1 or 1->0 transition of hex_mode forces a refresh. Switching back to decimal forces a reconversion.
- Undefined: the port is absent and the block is decimal-only.

Test Plan:
1. Apply reset for 2 cycles -> hex0=1000000, hex1..hex5=1111111, in_port=0, busy=0.
2. Set out_port=123456 -> busy=1 for exactly 21 cycles. Then hex5..hex0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010.
3. Set out_port=32'hFFF0_002A -> displays 42: hex1=0011001, hex0=0100100, hex2..hex5 blank. Then out_port=1000000 -> all six digits = 0111111.
4. Set out_port=5, then change it to 9 on the 3rd CONV cycle -> first 5 is shown (hex0=0010010), then a second busy pulse of 21 cycles, final hex0=0010000.
5. With DEB_CYCLES=4:
   - sw[0] rises and holds -> in_port[0]=1 exactly 6 edges later.
   - A 2-cycle pulse on sw[1] -> in_port[1] stays 0.
   - key[2] held low -> in_port[12]=1.
6. Assert reset during CONV of value 777 -> busy=0 and hex0=1000000 on the next edge. After release, 777 is converted again: hex2..hex0 = 1111000 x3.
